// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sram_arb_pkg
//  Purpose  : Shared widths, FSM state encoding and grant-latch record for
//             the two-port external SRAM arbiter.
//  Contents : ADDR_W, DATA_W, sram_arb_state_t, sram_req_t
//  Revision : 1.0  initial release
// ============================================================================
package sram_arb_pkg;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } sram_arb_state_t;

  // Everything about the winning request that must stay stable for the
  // whole transfer, captured in the grant cycle.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } sram_req_t;

endpackage : sram_arb_pkg
`default_nettype wire

// File: rtl/rr_grant2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_grant2
//  Purpose  : Combinational round-robin winner select for two requesters.
//  Ports    : req[1:0]  in   request vector
//             prio      in   preferred port when both request
//             grant[1:0] out one-hot grant (all zero with no request)
//             idx       out  index of the winning port
//  Revision : 1.0  initial release
// ============================================================================
module rr_grant2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] grant,
  output logic       idx
);

  always_comb begin
    idx   = 1'b0;
    grant = 2'b00;
    case (req)
      2'b01:   idx = 1'b0;
      2'b10:   idx = 1'b1;
      2'b11:   idx = prio;
      default: idx = 1'b0;
    endcase
    if (req != 2'b00) begin
      grant = idx ? 2'b10 : 2'b01;
    end
  end

endmodule : rr_grant2
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sram_arbiter
//  Purpose  : Two-port round-robin arbiter and access sequencer for a single
//             16-bit x 1M-word asynchronous SRAM.
//  Ports    : Clk, Reset (async, active high)
//             req0/1, we0/1, addr0/1, wdata0/1   requester inputs
//             ack0/1, rdata0/1                   requester responses
//             busy                               high outside IDLE
//             SRAM_ADDR, Data_to_SRAM, Data_from_SRAM,
//             SRAM_CE_N, SRAM_OE_N, SRAM_WE_N    SRAM side
//  Params   : WAIT_CYCLES  ACCESS cycles per transfer (1..15)
//  Revision : 1.0  initial release
// ============================================================================
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic [DATA_W-1:0] Data_to_SRAM,
  input  logic [DATA_W-1:0] Data_from_SRAM,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N
);

  localparam logic [3:0] c_cnt_load = 4'(WAIT_CYCLES - 1);

  sram_arb_state_t   r_state;
  sram_arb_state_t   w_state_nxt;
  logic              w_grant_now;
  logic              w_last_access;

  logic              r_prio;
  logic              r_port;
  logic [3:0]        r_cnt;
  sram_req_t         r_req;
  sram_req_t         w_req_sel;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;

  logic [1:0]        w_grant;
  logic              w_idx;

  rr_grant2 u_rr (
    .req   ({req1, req0}),
    .prio  (r_prio),
    .grant (w_grant),
    .idx   (w_idx)
  );

  // Request record of the round-robin winner.
  always_comb begin
    w_req_sel = '0;
    if (w_idx) begin
      w_req_sel.we    = we1;
      w_req_sel.addr  = addr1;
      w_req_sel.wdata = wdata1;
    end else begin
      w_req_sel.we    = we0;
      w_req_sel.addr  = addr0;
      w_req_sel.wdata = wdata0;
    end
  end

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and outputs. Strobes and acks decode straight from the
  // state register, so an asynchronous reset releases the SRAM at once and
  // suppresses any pending ack.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_grant_now   = 1'b0;
    w_last_access = 1'b0;
    ack0          = 1'b0;
    ack1          = 1'b0;
    busy          = 1'b1;
    SRAM_CE_N     = 1'b1;
    SRAM_OE_N     = 1'b1;
    SRAM_WE_N     = 1'b1;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (w_grant != 2'b00) begin
          w_grant_now = 1'b1;
          w_state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        SRAM_CE_N = 1'b0;
        SRAM_OE_N = r_req.we;
        SRAM_WE_N = ~r_req.we;
        if (r_cnt == 4'd0) begin
          w_last_access = 1'b1;
          w_state_nxt   = DONE;
        end
      end
      DONE: begin
        // Chip stays selected with address held so WE_N rises cleanly.
        SRAM_CE_N   = 1'b0;
        ack0        = ~r_port;
        ack1        = r_port;
        w_state_nxt = IDLE;
      end
      default: begin
        busy        = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Grant latch, wait counter, priority and read-data capture
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_prio   <= 1'b0;
      r_port   <= 1'b0;
      r_cnt    <= 4'd0;
      r_req    <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      if (w_grant_now) begin
        r_req  <= w_req_sel;
        r_port <= w_idx;
        r_prio <= ~w_idx;
        r_cnt  <= c_cnt_load;
      end else if (r_state == ACCESS && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end

      if (w_last_access && !r_req.we) begin
        if (r_port) begin
          r_rdata1 <= Data_from_SRAM;
        end else begin
          r_rdata0 <= Data_from_SRAM;
        end
      end
    end
  end

  // Address and write data hold their last values through IDLE.
  assign SRAM_ADDR    = r_req.addr;
  assign Data_to_SRAM = r_req.wdata;
  assign rdata0       = r_rdata0;
  assign rdata1       = r_rdata1;

endmodule : sram_arbiter
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_arbiter
//  Purpose  : Directed self-checking bench for sram_arbiter (WAIT_CYCLES=2)
//             plus WAIT_CYCLES=1 and WAIT_CYCLES=15 instances for latency.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1;
  logic [19:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic [15:0] din;
  logic        ack0, ack1, busy;
  logic [15:0] rdata0, rdata1;
  logic [19:0] sram_addr;
  logic [15:0] sram_dout;
  logic        ce_n, oe_n, we_n;

  // WAIT_CYCLES=1 and 15 instances
  logic        rq_a, rq_b;
  logic        ack_a0, ack_a1, busy_a, ce_a, oe_a, we_a;
  logic        ack_b0, ack_b1, busy_b, ce_b, oe_b, we_b;
  logic [15:0] rd_a0, rd_a1, sd_a, rd_b0, rd_b1, sd_b;
  logic [19:0] sa_a, sa_b;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.WAIT_CYCLES(2)) u_dut (
    .Clk(clk), .Reset(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
    .SRAM_ADDR(sram_addr), .Data_to_SRAM(sram_dout), .Data_from_SRAM(din),
    .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n)
  );

  sram_arbiter #(.WAIT_CYCLES(1)) u_dut_w1 (
    .Clk(clk), .Reset(rst),
    .req0(rq_a), .req1(1'b0), .we0(we0), .we1(1'b0),
    .addr0(addr0), .addr1(20'h0), .wdata0(wdata0), .wdata1(16'h0),
    .ack0(ack_a0), .ack1(ack_a1), .rdata0(rd_a0), .rdata1(rd_a1), .busy(busy_a),
    .SRAM_ADDR(sa_a), .Data_to_SRAM(sd_a), .Data_from_SRAM(din),
    .SRAM_CE_N(ce_a), .SRAM_OE_N(oe_a), .SRAM_WE_N(we_a)
  );

  sram_arbiter #(.WAIT_CYCLES(15)) u_dut_w15 (
    .Clk(clk), .Reset(rst),
    .req0(rq_b), .req1(1'b0), .we0(we0), .we1(1'b0),
    .addr0(addr0), .addr1(20'h0), .wdata0(wdata0), .wdata1(16'h0),
    .ack0(ack_b0), .ack1(ack_b1), .rdata0(rd_b0), .rdata1(rd_b1), .busy(busy_b),
    .SRAM_ADDR(sa_b), .Data_to_SRAM(sd_b), .Data_from_SRAM(din),
    .SRAM_CE_N(ce_b), .SRAM_OE_N(oe_b), .SRAM_WE_N(we_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Outputs depend only on registers, so sampling 2 time units after the
  // rising edge sees settled values; inputs are changed after sampling.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // One isolated transfer on one port; ack expected 3 cycles after request.
  task automatic xfer(input string tag, input bit port, input logic wr,
                      input logic [19:0] a, input logic [15:0] wd, input logic [15:0] dv);
    int lat, n_oe, n_we, n_ack, n_other, bad_a, bad_d, both;
    lat = -1; n_oe = 0; n_we = 0; n_ack = 0; n_other = 0; bad_a = 0; bad_d = 0; both = 0;
    din = dv;
    if (port) begin
      req1 = 1'b1; we1 = wr; addr1 = a; wdata1 = wd;
    end else begin
      req0 = 1'b1; we0 = wr; addr0 = a; wdata0 = wd;
    end
    for (int k = 1; k <= 10; k++) begin
      cyc();
      if (!oe_n) n_oe++;
      if (!we_n) n_we++;
      if (!ce_n && sram_addr !== a) bad_a++;
      if (!ce_n && wr && sram_dout !== wd) bad_d++;
      if (ack0 && ack1) both++;
      if (port ? ack0 : ack1) n_other++;
      if (port ? ack1 : ack0) begin
        n_ack++;
        if (lat < 0) lat = k;
        if (port) req1 = 1'b0; else req0 = 1'b0;
      end
    end
    chk({tag, "_lat"}, lat, 3);
    chk({tag, "_nack"}, n_ack, 1);
    chk({tag, "_other_ack"}, n_other, 0);
    chk({tag, "_oe_low"}, n_oe, wr ? 0 : 2);
    chk({tag, "_we_low"}, n_we, wr ? 2 : 0);
    chk({tag, "_addr"}, bad_a, 0);
    chk({tag, "_wdata"}, bad_d, 0);
    chk({tag, "_ack_both"}, both, 0);
    chk({tag, "_busy_end"}, busy, 1'b0);
    if (!wr) chk({tag, "_rdata"}, port ? rdata1 : rdata0, dv);
  endtask

  initial begin
    int both, lat_a, lat_b, n_ack;
    rst = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; din = '0;
    rq_a = 0; rq_b = 0;
    repeat (2) cyc();

    // Reset values
    chk("rst_strobes", {ce_n, oe_n, we_n}, 3'b111);
    chk("rst_busy", busy, 1'b0);
    chk("rst_acks", {ack1, ack0}, 2'b00);
    chk("rst_addr", sram_addr, 20'h0);
    chk("rst_dout", sram_dout, 16'h0);
    chk("rst_rdata", {rdata1, rdata0}, 32'h0);
    rst = 1'b0;
    cyc();

    xfer("rd_p0", 1'b0, 1'b0, 20'h00010, 16'h0000, 16'hBEEF);
    xfer("wr_p1", 1'b1, 1'b1, 20'hFFFFF, 16'h1234, 16'h0000);

    // Both ports requesting continuously: 0,1,0,1 with acks 4 apart
    req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 20'h00100; addr1 = 20'h00200;
    din = 16'h5A5A;
    both = 0;
    for (int k = 1; k <= 16; k++) begin
      logic [1:0] exp;
      cyc();
      exp = (k == 3 || k == 11) ? 2'b01 : (k == 7 || k == 15) ? 2'b10 : 2'b00;
      chk($sformatf("alt_k%0d", k), {ack1, ack0}, exp);
      if (ack0 && ack1) both++;
      if (k == 15) begin req0 = 0; req1 = 0; end
    end
    chk("alt_both", both, 0);
    chk("alt_rdata1", rdata1, 16'h5A5A);

    // Reset in the second ACCESS cycle of a port-0 read (priority now 1)
    cyc();
    req0 = 1; addr0 = 20'h00ABC; din = 16'h1111;
    cyc();
    cyc();
    chk("pre_rst_ce", ce_n, 1'b0);
    rst = 1'b1;
    #1;
    chk("arst_strobes", {ce_n, oe_n, we_n}, 3'b111);
    chk("arst_busy", busy, 1'b0);
    chk("arst_acks", {ack1, ack0}, 2'b00);
    chk("arst_addr", sram_addr, 20'h0);
    chk("arst_rdata0", rdata0, 16'h0);
    req1 = 1;
    cyc();
    chk("rst_hold_acks", {ack1, ack0}, 2'b00);
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk($sformatf("post_rst_k%0d", k), {ack1, ack0}, (k == 3) ? 2'b01 : 2'b00);
      if (k == 3) begin req0 = 0; req1 = 0; end
    end
    chk("post_rst_rdata0", rdata0, 16'h1111);
    repeat (3) cyc();

    // Dropped request mid-ACCESS still completes with one ack
    req0 = 1; we0 = 0; addr0 = 20'h00777; din = 16'h2222;
    n_ack = 0;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      chk($sformatf("drop_k%0d", k), ack0, (k == 3) ? 1'b1 : 1'b0);
      if (ack0) n_ack++;
      if (k == 1) req0 = 0;
    end
    chk("drop_nack", n_ack, 1);
    chk("drop_busy", busy, 1'b0);
    chk("drop_rdata0", rdata0, 16'h2222);

    // WAIT_CYCLES=1 and 15: latency 2 and 16, last-cycle data captured
    addr0 = 20'h00042; we0 = 0; din = 16'hC000;
    rq_a = 1; rq_b = 1; lat_a = -1; lat_b = -1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (ack_a0 && lat_a < 0) begin lat_a = k; rq_a = 0; end
      if (ack_b0 && lat_b < 0) begin lat_b = k; rq_b = 0; end
      din = 16'hC000 + 16'(k);
    end
    chk("w1_lat", lat_a, 2);
    chk("w15_lat", lat_b, 16);
    chk("w1_rdata", rd_a0, 16'hC001);
    chk("w15_rdata", rd_b0, 16'hC00F);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule : tb_sram_arbiter
`default_nettype wire
